// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: light codes and phase encoding.
package traffic_pkg;

  // Light codes shared with the intersection light FSM
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  // Phases of the timed sequencer
  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    WALK  = 3'd6
  } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter measuring how long the sequencer has been in its current phase.
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clr,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_elapsed
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_elapsed;

  // Count ticks, restart on a phase change, and hold at the top value instead of wrapping
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_elapsed <= '0;
    end else if (i_clr) begin
      r_elapsed <= '0;
    end else if (i_tick && (r_elapsed != C_MAX)) begin
      r_elapsed <= r_elapsed + CNT_W'(1);
    end
  end

  assign o_elapsed = r_elapsed;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Demand-actuated two-road intersection sequencer with a latched pedestrian phase.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 6,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 1,
  parameter int WALK_T    = 6
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick,
  input  logic       i_car_a,
  input  logic       i_car_b,
  input  logic       i_ped_req,
  output logic [1:0] o_la,
  output logic [1:0] o_lb,
  output logic       o_walk,
  output logic       o_ped_pend
);

  localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] C_WALK = CNT_W'(WALK_T - 1);

  phase_t           r_state;
  phase_t           w_nextState;
  logic             r_pedPend;
  logic             r_nextB;
  logic             w_nextBSet;
  logic             w_nextBVal;
  logic             w_clr;
  logic             w_pedAny;
  logic             w_demA;
  logic             w_demB;
  logic             w_enterWalk;
  logic [CNT_W-1:0] w_elapsed;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (w_clr),
    .i_tick    (i_tick),
    .o_elapsed (w_elapsed)
  );

  // A request arriving on the deciding tick already counts as demand
  assign w_pedAny    = r_pedPend | i_ped_req;
  assign w_demA      = i_car_a | w_pedAny;
  assign w_demB      = i_car_b | w_pedAny;
  assign w_clr       = (w_nextState != r_state);
  assign w_enterWalk = (w_nextState == WALK) && (r_state != WALK);

  // Next-phase decision, taken only on tick cycles, plus which road follows a walk phase
  always_comb begin
    w_nextState = r_state;
    w_nextBSet  = 1'b0;
    w_nextBVal  = r_nextB;
    if (i_tick) begin
      unique case (r_state)
        A_GRN: begin
          if (w_demB && (((w_elapsed >= C_GMIN) && !i_car_a) || (w_elapsed >= C_GMAX))) begin
            w_nextState = A_YEL;
          end
        end
        A_YEL: begin
          if (w_elapsed >= C_YEL) w_nextState = AR_AB;
        end
        AR_AB: begin
          if (w_elapsed >= C_AR) begin
            if (w_pedAny) begin
              w_nextState = WALK;
              w_nextBSet  = 1'b1;
              w_nextBVal  = 1'b1;
            end else begin
              w_nextState = B_GRN;
            end
          end
        end
        B_GRN: begin
          if (w_demA && (((w_elapsed >= C_GMIN) && !i_car_b) || (w_elapsed >= C_GMAX))) begin
            w_nextState = B_YEL;
          end
        end
        B_YEL: begin
          if (w_elapsed >= C_YEL) w_nextState = AR_BA;
        end
        AR_BA: begin
          if (w_elapsed >= C_AR) begin
            if (w_pedAny) begin
              w_nextState = WALK;
              w_nextBSet  = 1'b1;
              w_nextBVal  = 1'b0;
            end else begin
              w_nextState = A_GRN;
            end
          end
        end
        WALK: begin
          if (w_elapsed >= C_WALK) w_nextState = r_nextB ? B_GRN : A_GRN;
        end
        default: w_nextState = A_GRN;
      endcase
    end
  end

  // Phase register, pedestrian latch (walk entry consumes the request) and post-walk road choice
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= A_GRN;
      r_pedPend <= 1'b0;
      r_nextB   <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (w_enterWalk) begin
        r_pedPend <= 1'b0;
      end else if (i_ped_req) begin
        r_pedPend <= 1'b1;
      end
      if (w_nextBSet) begin
        r_nextB <= w_nextBVal;
      end
    end
  end

  // Lamp decode straight from the phase register
  always_comb begin
    o_la   = RED;
    o_lb   = RED;
    o_walk = 1'b0;
    unique case (r_state)
      A_GRN:   o_la   = GREEN;
      A_YEL:   o_la   = YELLOW;
      B_GRN:   o_lb   = GREEN;
      B_YEL:   o_lb   = YELLOW;
      WALK:    o_walk = 1'b1;
      default: begin
        o_la   = RED;
        o_lb   = RED;
        o_walk = 1'b0;
      end
    endcase
  end

  assign o_ped_pend = r_pedPend;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: fixed vectors, timed phase sequences and random traffic.
module tb_traffic_phase_sequencer;

  localparam int GMIN = 8;
  localparam int GMAX = 32;
  localparam int YEL  = 3;
  localparam int AR   = 1;
  localparam int WLK  = 6;
  localparam int SAT  = 63;

  localparam int P_AG   = 0;
  localparam int P_AY   = 1;
  localparam int P_ARAB = 2;
  localparam int P_BG   = 3;
  localparam int P_BY   = 4;
  localparam int P_ARBA = 5;
  localparam int P_WALK = 6;

  typedef struct {
    logic       r;
    logic       t;
    logic       ca;
    logic       cb;
    logic       pr;
    logic [1:0] la;
    logic [1:0] lb;
    logic       wk;
    logic       pd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       car_a = 1'b0;
  logic       car_b = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] la;
  logic [1:0] lb;
  logic       walk;
  logic       pend;

  int nChecks = 0;
  int nFails  = 0;

  int mPhase  = P_AG;
  int mTicks  = 0;
  bit mPend   = 1'b0;
  bit mNextB  = 1'b1;

  traffic_phase_sequencer dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_tick     (tick),
    .i_car_a    (car_a),
    .i_car_b    (car_b),
    .i_ped_req  (ped_req),
    .o_la       (la),
    .o_lb       (lb),
    .o_walk     (walk),
    .o_ped_pend (pend)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int modelLights(input int p);
    int a;
    int b;
    a = (p == P_AG) ? 2 : (p == P_AY) ? 1 : 0;
    b = (p == P_BG) ? 2 : (p == P_BY) ? 1 : 0;
    return a * 4 + b;
  endfunction

  // Reference: phase durations counted in ticks, next phase picked from demand rules
  task automatic modelStep(input logic r, input logic t, input logic ca, input logic cb, input logic pr);
    int nxt;
    int done;
    bit pendNow;
    if (!r) begin
      mPhase = P_AG;
      mTicks = 0;
      mPend  = 1'b0;
      mNextB = 1'b1;
      return;
    end
    pendNow = mPend | pr;
    nxt     = mPhase;
    done    = mTicks + 1;
    if (t) begin
      case (mPhase)
        P_AG:   if ((cb || pendNow) && ((done >= GMIN && !ca) || done >= GMAX)) nxt = P_AY;
        P_AY:   if (done >= YEL) nxt = P_ARAB;
        P_ARAB: if (done >= AR) begin
                  nxt = pendNow ? P_WALK : P_BG;
                  if (pendNow) mNextB = 1'b1;
                end
        P_BG:   if ((ca || pendNow) && ((done >= GMIN && !cb) || done >= GMAX)) nxt = P_BY;
        P_BY:   if (done >= YEL) nxt = P_ARBA;
        P_ARBA: if (done >= AR) begin
                  nxt = pendNow ? P_WALK : P_AG;
                  if (pendNow) mNextB = 1'b0;
                end
        P_WALK: if (done >= WLK) nxt = mNextB ? P_BG : P_AG;
        default: nxt = P_AG;
      endcase
    end
    if (nxt != mPhase) begin
      mTicks = 0;
      mPend  = (nxt == P_WALK) ? 1'b0 : pendNow;
    end else begin
      if (t) mTicks++;
      mPend = pendNow;
    end
    mPhase = nxt;
  endtask

  // One clock cycle: drive on the falling edge, compare against the reference after the rising edge
  task automatic applyStimulus(input logic r, input logic t, input logic ca, input logic cb, input logic pr);
    int expL;
    @(negedge clk);
    reset_n = r;
    tick    = t;
    car_a   = ca;
    car_b   = cb;
    ped_req = pr;
    modelStep(r, t, ca, cb, pr);
    @(posedge clk);
    #1;
    expL = modelLights(mPhase);
    checkOutput("model lights/walk/pend", {26'd0, la, lb, walk, pend},
                expL * 4 + ((mPhase == P_WALK) ? 2 : 0) + int'(mPend));
    checkOutput("model elapsed", int'(dut.w_elapsed), (mTicks > SAT) ? SAT : mTicks);
  endtask

  task automatic tickPair(input logic ca, input logic cb, input logic pr);
    applyStimulus(1'b1, 1'b1, ca, cb, pr);
    applyStimulus(1'b1, 1'b0, ca, cb, 1'b0);
  endtask

  task automatic doReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Count ticks while the lamps show the given pattern, giving up after limit ticks
  task automatic measurePhase(input logic [1:0] ela, input logic [1:0] elb, input logic ew,
                              input logic ca, input logic cb, input int limit, output int n);
    n = 0;
    while (la == ela && lb == elb && walk == ew && n < limit) begin
      tickPair(ca, cb, 1'b0);
      n++;
    end
  endtask

  vec_t vecs[8];
  int   n;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};

    // Fixed vectors around reset and the pedestrian latch
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].r, vecs[i].t, vecs[i].ca, vecs[i].cb, vecs[i].pr);
      checkOutput($sformatf("vec%0d la", i), int'(la), int'(vecs[i].la));
      checkOutput($sformatf("vec%0d lb", i), int'(lb), int'(vecs[i].lb));
      checkOutput($sformatf("vec%0d walk", i), int'(walk), int'(vecs[i].wk));
      checkOutput($sformatf("vec%0d pend", i), int'(pend), int'(vecs[i].pd));
    end

    // No demand: A green holds
    doReset();
    checkOutput("reset la", int'(la), 2);
    checkOutput("reset pend", int'(pend), 0);
    measurePhase(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 100, n);
    checkOutput("idle hold ticks", n, 100);

    // Max-out on both roads
    doReset();
    measurePhase(2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 100, n);
    checkOutput("A max-out green", n, GMAX);
    measurePhase(2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 100, n);
    checkOutput("A yellow", n, YEL);
    measurePhase(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 100, n);
    checkOutput("A all-red", n, AR);
    checkOutput("B green after max-out", int'(lb), 2);
    measurePhase(2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 100, n);
    checkOutput("B max-out green", n, GMAX);
    measurePhase(2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 100, n);
    checkOutput("B yellow", n, YEL);
    measurePhase(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 100, n);
    checkOutput("B all-red", n, AR);
    checkOutput("A green again", int'(la), 2);

    // Gap-out
    doReset();
    measurePhase(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 100, n);
    checkOutput("gap-out green", n, GMIN);
    measurePhase(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 100, n);
    checkOutput("gap-out yellow", n, YEL);
    measurePhase(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 100, n);
    checkOutput("gap-out all-red", n, AR);
    checkOutput("gap-out B green", int'(lb), 2);

    // Pedestrian phase, with a second press on the walk entry cycle
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ped latched", int'(pend), 1);
    measurePhase(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 100, n);
    checkOutput("ped green", n, GMIN);
    measurePhase(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 100, n);
    checkOutput("ped yellow", n, YEL);
    checkOutput("ped all-red lamps", {30'd0, la} + {30'd0, lb} + int'(walk), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("walk on entry", int'(walk), 1);
    checkOutput("pend cleared on entry", int'(pend), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    measurePhase(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 100, n);
    checkOutput("walk ticks", n, WLK);
    checkOutput("B green after walk", int'(lb), 2);
    checkOutput("pend after walk", int'(pend), 0);

    // Frozen timebase during yellow
    doReset();
    measurePhase(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 100, n);
    checkOutput("freeze green", n, GMIN);
    tickPair(1'b0, 1'b1, 1'b0);
    repeat (50) applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    checkOutput("freeze la", int'(la), 1);
    checkOutput("freeze elapsed", int'(dut.w_elapsed), 1);
    measurePhase(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 100, n);
    checkOutput("yellow after freeze", n, YEL - 1);

    // Reset in the middle of a walk phase with a pending request
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    measurePhase(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 100, n);
    measurePhase(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 100, n);
    tickPair(1'b0, 1'b0, 1'b0);
    tickPair(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pre-reset walk", int'(walk), 1);
    checkOutput("pre-reset pend", int'(pend), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid reset la", int'(la), 2);
    checkOutput("mid reset lb", int'(lb), 0);
    checkOutput("mid reset walk", int'(walk), 0);
    checkOutput("mid reset pend", int'(pend), 0);
    checkOutput("mid reset elapsed", int'(dut.w_elapsed), 0);

    // Random traffic against the reference
    doReset();
    begin
      logic ca;
      logic cb;
      ca = 1'b0;
      cb = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(7) == 0) ca = ~ca;
        if ($urandom_range(7) == 0) cb = ~cb;
        applyStimulus(($urandom_range(699) != 0), 1'($urandom_range(1)), ca, cb,
                      ($urandom_range(39) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
